// File: rtl/um245r_rx_reader_if.sv
// rtl/um245r_rx_reader_if.sv - UM245R receive pins and CPU-side receive stream bundle
interface um245r_rx_reader_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Device side
  logic          _rxf;
  logic [7:0]    d_in;
  logic          _rd;
  logic          rd_active;

  // CPU side
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] rx_count;

  // The reader drives the strobe and the receive stream
  modport master (
    input  _rxf, d_in, rx_ready,
    output _rd, rd_active, rx_data, rx_valid, rx_count
  );

  // The device pins and the consumer drive the rest
  modport slave (
    output _rxf, d_in, rx_ready,
    input  _rd, rd_active, rx_data, rx_valid, rx_count
  );
endinterface

// File: rtl/um245r_rx_reader.sv
// rtl/um245r_rx_reader.sv - UM245R receive controller with _RD strobe timing and receive FIFO
module um245r_rx_reader #(
  parameter int RD_PULSE_CYCLES   = 3,
  parameter int RD_RECOVER_CYCLES = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic               clk,
  input  logic               _reset,
  um245r_rx_reader_if.master bus
);
  localparam int              AW           = $clog2(FIFO_DEPTH);
  localparam int              CW           = AW + 1;
  localparam logic [4:0]      PULSE_LAST   = 5'(RD_PULSE_CYCLES - 1);
  // Two extra recovery clocks let the stale low level drain out of the synchroniser
  localparam logic [4:0]      RECOVER_LAST = 5'(RD_RECOVER_CYCLES + 1);
  localparam logic [CW-1:0]   DEPTH        = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_LOW, RECOVER} state_t;

  state_t        state;
  logic [4:0]    cnt;
  logic          rxf_meta;
  logic          rxf_s;
  logic          rd_n;
  logic          rd_act;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Capture happens on the edge that ends the low pulse; space was reserved when the read began
  assign push = (state == RD_LOW) && (cnt == PULSE_LAST);
  assign pop  = (count != '0) && bus.rx_ready;

  assign bus._rd       = rd_n;
  assign bus.rd_active = rd_act;
  assign bus.rx_data   = mem[rd_ptr];
  assign bus.rx_valid  = (count != '0);
  assign bus.rx_count  = count;

  // Two-flop synchroniser for the asynchronous _rxf pin, idling at the inactive level
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= bus._rxf;
      rxf_s    <= rxf_meta;
    end
  end

  // Read sequencer: start only with free space, hold _rd low, then recover before trusting _rxf
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_n   <= 1'b1;
      rd_act <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxf_s && (count < DEPTH)) begin
            state  <= RD_LOW;
            cnt    <= '0;
            rd_n   <= 1'b0;
            rd_act <= 1'b1;
          end
        end
        RD_LOW: begin
          if (cnt == PULSE_LAST) begin
            state  <= RECOVER;
            cnt    <= '0;
            rd_n   <= 1'b1;
            rd_act <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RECOVER: begin
          if (cnt == RECOVER_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          rd_n   <= 1'b1;
          rd_act <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO: pointers wrap naturally, the full count keeps full and empty distinct
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.d_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_um245r_rx_reader.sv
// tb/tb_um245r_rx_reader.sv - scoreboard bench for the UM245R receive reader
module tb_um245r_rx_reader;
  logic clk = 1'b0;
  logic _reset;

  always #5 clk = ~clk;

  um245r_rx_reader_if #(.FIFO_DEPTH(4)) bus ();

  um245r_rx_reader #(
    .RD_PULSE_CYCLES(3),
    .RD_RECOVER_CYCLES(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    ._reset(_reset),
    .bus(bus)
  );

  logic [7:0] dev_mem [64];
  int         fed;
  int         taken;
  bit         rxf_hold;
  logic [7:0] exp_q [$];
  int         n_cmp;
  int         n_fail;

  // Device model: data is available while unread bytes remain and the post-read hold has expired
  always_comb begin
    bus._rxf = rxf_hold || (fed == taken);
    bus.d_in = dev_mem[taken[5:0]];
  end

  // A completed strobe (not one forced high by reset) consumes the byte at the head
  initial begin
    forever begin
      @(posedge bus._rd);
      if (_reset === 1'b1 && fed != taken) begin
        taken    = taken + 1;
        rxf_hold = 1'b1;
        #12;
        rxf_hold = 1'b0;
      end
    end
  end

  // Monitor: every accepted beat must match the oldest expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_pop_unexpected: got %02h want no data", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rx_data !== e) begin
            n_fail++;
            $display("FAIL rx_data_order: got %02h want %02h", bus.rx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    dev_mem[fed[5:0]] = b;
    exp_q.push_back(b);
    fed = fed + 1;
  endtask

  task automatic wait_rd_fall(input string name, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus._rd !== 1'b0 && edges < 100);
    check({name, "_fell"}, bus._rd, 0);
  endtask

  task automatic measure_low(output int w);
    w = 0;
    while (bus._rd === 1'b0 && w < 100) begin
      w++;
      tick();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.rx_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.rx_count != 0 || fed != taken) && n < 300) begin
      tick();
      n++;
    end
    bus.rx_ready = 1'b0;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_count0"}, bus.rx_count, 0);
    repeat (8) tick();
  endtask

  initial begin
    int   e;
    int   w;
    int   n;
    int   lows;
    int   falls;
    logic prev;

    _reset       = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (2) tick();
    check("rst_rd", bus._rd, 1);
    check("rst_rd_active", bus.rd_active, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_count", bus.rx_count, 0);
    _reset = 1'b1;
    tick();

    // Single byte with no consumer
    feed(8'h61);
    wait_rd_fall("single", e);
    check("single_latency", e, 3);
    check("single_rd_active", bus.rd_active, 1);
    measure_low(w);
    check("single_low_width", w, 3);
    check("single_rd_active_off", bus.rd_active, 0);
    check("single_valid", bus.rx_valid, 1);
    check("single_data", bus.rx_data, 8'h61);
    check("single_count", bus.rx_count, 1);
    drain("single");

    // Stream with consumer always ready
    feed(8'h61); feed(8'h62); feed(8'h63); feed(8'h64);
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rd_fall("stream", e);
      if (i == 0) check("stream_latency", e, 3);
      else        check("stream_gap", e, 5);
      measure_low(w);
      check("stream_low_width", w, 3);
    end
    drain("stream");

    // Backpressure: FIFO fills, strobe stays idle until space appears
    for (int i = 0; i < 6; i++) feed(8'(8'h10 + i));
    n = 0;
    while (bus.rx_count != 4 && n < 200) begin
      tick();
      n++;
    end
    check("bp_full_count", bus.rx_count, 4);
    lows = 0;
    repeat (20) begin
      tick();
      if (bus._rd === 1'b0) lows++;
    end
    check("bp_rd_held_high", lows, 0);
    check("bp_count_still4", bus.rx_count, 4);
    check("bp_dev_pending", fed - taken, 2);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    falls = 0;
    prev  = 1'b1;
    repeat (30) begin
      tick();
      if (prev === 1'b1 && bus._rd === 1'b0) falls++;
      prev = bus._rd;
    end
    check("bp_one_more_read", falls, 1);
    check("bp_count_back4", bus.rx_count, 4);
    check("bp_dev_pending_after", fed - taken, 1);
    drain("bp");

    // Pop on the capture edge with two entries held
    feed(8'h20); feed(8'h21);
    n = 0;
    while (bus.rx_count != 2 && n < 100) begin
      tick();
      n++;
    end
    check("pp_setup_count", bus.rx_count, 2);
    feed(8'h22);
    wait_rd_fall("pp", e);
    tick();
    tick();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("pp_rd_released", bus._rd, 1);
    check("pp_count", bus.rx_count, 2);
    check("pp_head", bus.rx_data, 8'h21);
    drain("pp");

    // Reset two clocks into the low pulse
    feed(8'h5a);
    wait_rd_fall("rstmid", e);
    tick();
    tick();
    _reset = 1'b0;
    #1;
    check("rstmid_rd", bus._rd, 1);
    check("rstmid_rd_active", bus.rd_active, 0);
    check("rstmid_count", bus.rx_count, 0);
    check("rstmid_dev_kept", fed - taken, 1);
    tick();
    tick();
    _reset = 1'b1;
    drain("rstmid");
    check("rstmid_valid_after", bus.rx_valid, 0);

    // Pops while empty must not disturb the pointers
    bus.rx_ready = 1'b1;
    repeat (5) tick();
    check("empty_pop_count", bus.rx_count, 0);
    check("empty_pop_valid", bus.rx_valid, 0);
    feed(8'h77);
    drain("empty_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
